// File: rtl/bus_arbiter8_if.sv
// Bus arbiter signal bundle: request vector in, grant/select/valid/tenure count out.
// master = arbiter side, slave = requester/mux side.
interface bus_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] owner_cycles;

  modport master (
    input  req,
    output gnt,
    output sel,
    output valid,
    output owner_cycles
  );

  modport slave (
    output req,
    input  gnt,
    input  sel,
    input  valid,
    input  owner_cycles
  );
endinterface

// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter for 8 requesters sharing a 16-bit bus mux.
// Each tenure lasts at most MAX_HOLD cycles (1..255); at a tenure end the next
// winner is picked in the same edge, so there is no idle gap between owners.
// Optional macro ARB_PRIO0_EN: requester 0 wins every arbitration decision it
// takes part in (never preempts a running tenure).
module bus_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter8_if.master bus
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;

  logic [2:0] win;
  logic       win_ok;
  logic       tenure_end;

  // Rotating search from ptr: first requester at or after ptr (wrapping) wins.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (!win_ok && bus.req[ptr_q + 3'(k)]) begin
        win    = ptr_q + 3'(k);
        win_ok = 1'b1;
      end
    end
`ifdef ARB_PRIO0_EN
    if (bus.req[0]) begin
      win    = '0;
      win_ok = 1'b1;
    end
`endif
  end

  // Tenure ends when the owner lets go or has used its last allowed cycle.
  always_comb begin
    tenure_end = !bus.req[sel_q] || (cnt_q == HOLD_LAST);
  end

  // Next-state decode; a tenure end with requests pending goes straight to
  // the next winner, which may be the same owner as a fresh tenure.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE || tenure_end) begin
      if (win_ok) begin
        state_d = GRANT;
        gnt_d   = 8'b1 << win;
        sel_d   = win;
        valid_d = 1'b1;
        cnt_d   = '0;
        ptr_d   = win + 3'd1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Arbiter state and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.sel          = sel_q;
  assign bus.valid        = valid_q;
  assign bus.owner_cycles = cnt_q;

endmodule
